bp_uce_mem_mock: RTL

Single-outstanding, block-wide memory endpoint directly downstream of the UCE. It consumes the UCE's memory command stream and produces its memory response stream. It services cached fills (rd/wr), uncached reads and writes, and writebacks from an internal block array, with a configurable fixed latency. It is used for UCE-attached cache bring-up and as the memory side of UCE unit benches.

---
 rtl/bp_uce_mem_mock.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/bp_uce_mem_mock.sv
// -----------------------------------------------------------------------------
// bp_uce_mem_mock
//
// Single-outstanding, block-wide memory endpoint that sits directly below the
// UCE. It accepts one memory command at a time, performs the array access at
// the acceptance edge, and returns a response a fixed number of cycles later.
//
// Supported command types (bp_cce_mem_cmd_type_e encoding):
//   rd / wr : response carries the full block at the index, no array write
//   uc_rd   : response carries 2^size bytes from the aligned offset, low-justified
//   uc_wr   : 2^size low bytes of the command data are merged into the block
//   wb      : the full block is overwritten
//   other   : no array access, zero data, response still returned
//
// Handshakes:
//   Command side is valid/ready: a command is taken on a clock edge where
//   mem_cmd_v_i & mem_cmd_ready_o. Ready depends only on FSM state, never on
//   the valid input. Response side is valid/yumi: mem_resp_v_o stays high with
//   stable registered fields until the consumer pulses mem_resp_yumi_i, which
//   is only legal while mem_resp_v_o is high.
//
// Ports:
//   clk_i              clock
//   reset_i            asynchronous reset, active low
//   mem_cmd_*_i        command type / addr / size / payload / data / valid
//   mem_cmd_ready_o    command ready (only in the ready state)
//   mem_resp_*_o       echoed command fields plus response data and valid
//   mem_resp_yumi_i    consumer takes the response
//
// Array contents are not reset; a block is undefined until it is written.
// -----------------------------------------------------------------------------
module bp_uce_mem_mock #(
    parameter int paddr_width_p   = 40,
    parameter int block_width_p   = 512,
    parameter int mem_blocks_p    = 1024,
    parameter int payload_width_p = 16,
    parameter int mem_latency_p   = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,

    input  logic [3:0]                 mem_cmd_type_i,
    input  logic [paddr_width_p-1:0]   mem_cmd_addr_i,
    input  logic [2:0]                 mem_cmd_size_i,
    input  logic [payload_width_p-1:0] mem_cmd_payload_i,
    input  logic [block_width_p-1:0]   mem_cmd_data_i,
    input  logic                       mem_cmd_v_i,
    output logic                       mem_cmd_ready_o,

    output logic [3:0]                 mem_resp_type_o,
    output logic [paddr_width_p-1:0]   mem_resp_addr_o,
    output logic [2:0]                 mem_resp_size_o,
    output logic [payload_width_p-1:0] mem_resp_payload_o,
    output logic [block_width_p-1:0]   mem_resp_data_o,
    output logic                       mem_resp_v_o,
    input  logic                       mem_resp_yumi_i
);

    localparam int block_bytes_lp   = block_width_p / 8;
    localparam int offset_width_lp  = $clog2(block_bytes_lp);
    localparam int index_width_lp   = $clog2(mem_blocks_p);
    localparam int cnt_width_lp     = (mem_latency_p > 1) ? $clog2(mem_latency_p) : 1;

    localparam logic [3:0] cmd_rd_lp    = 4'd0;
    localparam logic [3:0] cmd_wr_lp    = 4'd1;
    localparam logic [3:0] cmd_uc_rd_lp = 4'd2;
    localparam logic [3:0] cmd_uc_wr_lp = 4'd3;
    localparam logic [3:0] cmd_wb_lp    = 4'd4;

    localparam logic [cnt_width_lp-1:0] cnt_load_lp = cnt_width_lp'(mem_latency_p - 1);
    localparam logic [cnt_width_lp-1:0] cnt_one_lp  = cnt_width_lp'(1);

    typedef enum logic [1:0] {
        e_reset = 2'd0,
        e_ready = 2'd1,
        e_busy  = 2'd2,
        e_resp  = 2'd3
    } state_e;

    state_e                    state_q, state_n;
    logic [cnt_width_lp-1:0]   cnt_q, cnt_n;
    logic                      accept;

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= e_reset;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and handshake outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_n         = state_q;
        cnt_n           = cnt_q;
        mem_cmd_ready_o = 1'b0;
        mem_resp_v_o    = 1'b0;
        accept          = 1'b0;

        case (state_q)
            e_reset: begin
                state_n = e_ready;
            end
            e_ready: begin
                mem_cmd_ready_o = 1'b1;
                if (mem_cmd_v_i) begin
                    accept = 1'b1;
                    cnt_n  = cnt_load_lp;
                    // With a latency of one the busy phase has zero length.
                    if (mem_latency_p == 1) begin
                        state_n = e_resp;
                    end else begin
                        state_n = e_busy;
                    end
                end
            end
            e_busy: begin
                // Leaving when the count hits zero keeps the total
                // acceptance-to-valid distance at exactly mem_latency_p.
                cnt_n = cnt_q - cnt_one_lp;
                if (cnt_q == cnt_one_lp) begin
                    state_n = e_resp;
                end
            end
            e_resp: begin
                mem_resp_v_o = 1'b1;
                if (mem_resp_yumi_i) begin
                    state_n = e_ready;
                end
            end
            default: begin
                state_n = e_reset;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Array datapath (evaluated against the command currently presented)
    // -------------------------------------------------------------------------
    logic [block_width_p-1:0]   mem_r [mem_blocks_p];

    logic [index_width_lp-1:0]  idx;
    logic [offset_width_lp-1:0] off_aligned;
    logic [2:0]                 size_c;
    logic [block_bytes_lp-1:0]  low_byte_mask;
    logic [block_width_p-1:0]   low_bit_mask;
    logic [block_width_p-1:0]   bit_mask;
    logic [block_width_p-1:0]   rd_block;
    logic [block_width_p-1:0]   wr_block;
    logic [block_width_p-1:0]   resp_data_n;
    logic                       wr_en;
    int                         nbytes;

    assign idx      = mem_cmd_addr_i[offset_width_lp +: index_width_lp];
    assign rd_block = mem_r[idx];

    always_comb begin
        size_c        = mem_cmd_size_i;
        nbytes        = 1;
        off_aligned   = '0;
        low_byte_mask = '0;
        low_bit_mask  = '0;
        bit_mask      = '0;
        wr_block      = '0;
        resp_data_n   = '0;
        wr_en         = 1'b0;

        // Sizes larger than a block are treated as a whole-block access.
        if (mem_cmd_size_i > 3'(offset_width_lp)) begin
            size_c = 3'(offset_width_lp);
        end
        nbytes = 1 << size_c;

        // Align the in-block offset down to the access size.
        off_aligned = mem_cmd_addr_i[offset_width_lp-1:0]
                      & ~(offset_width_lp'(nbytes - 1));

        for (int b = 0; b < block_bytes_lp; b++) begin
            low_byte_mask[b] = (b < nbytes);
        end
        for (int b = 0; b < block_bytes_lp; b++) begin
            low_bit_mask[8*b +: 8] = {8{low_byte_mask[b]}};
        end
        bit_mask = low_bit_mask << {off_aligned, 3'b000};

        case (mem_cmd_type_i)
            cmd_rd_lp, cmd_wr_lp: begin
                resp_data_n = rd_block;
            end
            cmd_uc_rd_lp: begin
                resp_data_n = (rd_block >> {off_aligned, 3'b000}) & low_bit_mask;
            end
            cmd_uc_wr_lp: begin
                wr_en    = 1'b1;
                wr_block = (rd_block & ~bit_mask)
                         | ((mem_cmd_data_i << {off_aligned, 3'b000}) & bit_mask);
            end
            cmd_wb_lp: begin
                wr_en    = 1'b1;
                wr_block = mem_cmd_data_i;
            end
            default: begin
                resp_data_n = '0;
            end
        endcase
    end

    // Array storage is deliberately not reset: writes committed at acceptance
    // survive a reset that lands while the response is still pending.
    always_ff @(posedge clk_i) begin
        if (accept && wr_en) begin
            mem_r[idx] <= wr_block;
        end
    end

    // -------------------------------------------------------------------------
    // Response registers, captured at acceptance and held until yumi
    // -------------------------------------------------------------------------
    logic [3:0]                 resp_type_r;
    logic [paddr_width_p-1:0]   resp_addr_r;
    logic [2:0]                 resp_size_r;
    logic [payload_width_p-1:0] resp_payload_r;
    logic [block_width_p-1:0]   resp_data_r;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            resp_type_r    <= '0;
            resp_addr_r    <= '0;
            resp_size_r    <= '0;
            resp_payload_r <= '0;
            resp_data_r    <= '0;
        end else if (accept) begin
            resp_type_r    <= mem_cmd_type_i;
            resp_addr_r    <= mem_cmd_addr_i;
            resp_size_r    <= mem_cmd_size_i;
            resp_payload_r <= mem_cmd_payload_i;
            resp_data_r    <= resp_data_n;
        end
    end

    assign mem_resp_type_o    = resp_type_r;
    assign mem_resp_addr_o    = resp_addr_r;
    assign mem_resp_size_o    = resp_size_r;
    assign mem_resp_payload_o = resp_payload_r;
    assign mem_resp_data_o    = resp_data_r;

endmodule
